// File: rtl/spi_xfer_fifo.sv
// spi_xfer_fifo: TX/RX byte FIFOs between the SPI register block and the shift engine, with a TX dispatch FSM.
// Define SPI_FIFO_RX_OVERWRITE_EN to make an RX overrun replace the oldest byte instead of dropping the new one.
module spi_xfer_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       tx_push_i,
   input  logic [7:0] tx_wdata_i,
   input  logic       rx_pop_i,
   output logic [7:0] rx_rdata_o,
   input  logic       flush_i,
   output logic       tx_full_o,
   output logic       tx_empty_o,
   output logic       rx_full_o,
   output logic       rx_empty_o,
   output logic       rx_overrun_o,
   output logic       active_o,
   output logic       eng_tx_valid_o,
   output logic [7:0] eng_tx_data_o,
   input  logic       eng_busy_i,
   input  logic       eng_rx_valid_i,
   input  logic [7:0] eng_rx_data_i
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
   logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
   logic [7:0]    tx_mem_q [DEPTH];
   logic [7:0]    rx_mem_q [DEPTH];
   logic [7:0]    eng_tx_data_q, eng_tx_data_d;
   logic          rx_overrun_q, rx_overrun_d;
   logic          tx_push_ok, tx_pop_ok, rx_pop_ok, rx_wr_en;

   // The extra pointer MSB tells a full FIFO apart from an empty one.
   assign tx_empty_o = (tx_wptr_q == tx_rptr_q);
   assign tx_full_o  = (tx_wptr_q[AW] != tx_rptr_q[AW]) && (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
   assign rx_empty_o = (rx_wptr_q == rx_rptr_q);
   assign rx_full_o  = (rx_wptr_q[AW] != rx_rptr_q[AW]) && (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);

   assign rx_rdata_o    = rx_mem_q[rx_rptr_q[AW-1:0]];
   assign rx_overrun_o  = rx_overrun_q;
   assign eng_tx_data_o = eng_tx_data_q;
   assign active_o      = (state_q != IDLE) || !tx_empty_o;

   always_comb begin
      tx_push_ok = tx_push_i && !tx_full_o && !flush_i;
      tx_pop_ok  = (state_q == IDLE) && !tx_empty_o && !flush_i;
      tx_wptr_d  = tx_wptr_q;
      tx_rptr_d  = tx_rptr_q;
      if (flush_i) begin
         tx_wptr_d = '0;
         tx_rptr_d = '0;
      end else begin
         if (tx_push_ok) tx_wptr_d = tx_wptr_q + PTR_ONE;
         if (tx_pop_ok)  tx_rptr_d = tx_rptr_q + PTR_ONE;
      end
   end

   // A coincident pop frees the slot, so a push onto a full FIFO only overruns without one.
   always_comb begin
      rx_pop_ok    = rx_pop_i && !rx_empty_o;
      rx_wr_en     = 1'b0;
      rx_wptr_d    = rx_wptr_q;
      rx_rptr_d    = rx_rptr_q;
      rx_overrun_d = rx_overrun_q;
      if (flush_i) begin
         rx_wptr_d    = '0;
         rx_rptr_d    = '0;
         rx_overrun_d = 1'b0;
      end else begin
         if (rx_pop_ok) rx_rptr_d = rx_rptr_q + PTR_ONE;
         if (eng_rx_valid_i) begin
            if (!rx_full_o || rx_pop_ok) begin
               rx_wr_en  = 1'b1;
               rx_wptr_d = rx_wptr_q + PTR_ONE;
            end else begin
               rx_overrun_d = 1'b1;
`ifdef SPI_FIFO_RX_OVERWRITE_EN
               rx_wr_en  = 1'b1;
               rx_wptr_d = rx_wptr_q + PTR_ONE;
               rx_rptr_d = rx_rptr_q + PTR_ONE;
`else
               rx_wr_en  = 1'b0;
`endif
            end
         end
      end
   end

   // Flush only abandons a launch that has not been strobed yet; once the engine owns a byte it must finish.
   always_comb begin
      state_d        = state_q;
      eng_tx_data_d  = eng_tx_data_q;
      eng_tx_valid_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (flush_i) begin
               eng_tx_data_d = '0;
            end else if (tx_pop_ok) begin
               eng_tx_data_d = tx_mem_q[tx_rptr_q[AW-1:0]];
               state_d       = LAUNCH;
            end
         end
         LAUNCH: begin
            if (flush_i) begin
               eng_tx_data_d = '0;
               state_d       = IDLE;
            end else begin
               eng_tx_valid_o = 1'b1;
               state_d        = WAIT_START;
            end
         end
         WAIT_START: if (eng_busy_i)  state_d = WAIT_DONE;
         WAIT_DONE:  if (!eng_busy_i) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         tx_wptr_q     <= '0;
         tx_rptr_q     <= '0;
         rx_wptr_q     <= '0;
         rx_rptr_q     <= '0;
         eng_tx_data_q <= '0;
         rx_overrun_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         tx_wptr_q     <= tx_wptr_d;
         tx_rptr_q     <= tx_rptr_d;
         rx_wptr_q     <= rx_wptr_d;
         rx_rptr_q     <= rx_rptr_d;
         eng_tx_data_q <= eng_tx_data_d;
         rx_overrun_q  <= rx_overrun_d;
      end
   end

   // Byte storage is deliberately left unreset.
   always_ff @(posedge clk_i) begin
      if (tx_push_ok) tx_mem_q[tx_wptr_q[AW-1:0]] <= tx_wdata_i;
      if (rx_wr_en)   rx_mem_q[rx_wptr_q[AW-1:0]] <= eng_rx_data_i;
   end

endmodule
